frog_game_ctrl: RTL and testbench

Game-flow controller that sits directly downstream of the VGA playfield/collision logic. Each frame it consumes the per-pixel collision flag and a goal-reached flag, then decides death or score. It alternates turns between two players, keeps 4-bit scores, and requests player respawn. Its state and scores drive the board LEDs and seven-segment display.

---
 rtl/frog_game_ctrl_pkg.sv | 23 ++
 rtl/frog_game_ctrl_if.sv | 26 ++
 rtl/frog_hit_latch.sv | 29 ++
 rtl/frog_game_ctrl.sv | 120 ++++++++++++
 tb/tb_frog_game_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/frog_game_ctrl_pkg.sv
// Shared definitions for the frog game-flow controller: state encodings,
// winner codes, score width and a turn-swap helper.
package frog_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // The playing state of the other player.
    function automatic state_t other_turn(input state_t s);
        return (s == QGAME_1) ? QGAME_2 : QGAME_1;
    endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Game-flow signal bundle between the playfield side (master) and the
// frog_game_ctrl block (slave).
interface frog_game_ctrl_if;
    import frog_pkg::*;

    logic               start;
    logic               frame_end;
    logic               collision;
    logic               goal;
    state_t             state;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               respawn;
    logic [1:0]         winner;

    modport master (
        output start, frame_end, collision, goal,
        input  state, p1_score, p2_score, respawn, winner
    );

    modport slave (
        input  start, frame_end, collision, goal,
        output state, p1_score, p2_score, respawn, winner
    );

endinterface

// File: rtl/frog_hit_latch.sv
// Sticky set/clear bit. q_now includes a set arriving this very cycle so the
// consumer can evaluate on the same cycle that clears the latch.
module frog_hit_latch (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic set,
    input  logic clr,
    output logic q,
    output logic q_now
);

    logic r_q;

    assign q_now = r_q | (en & set);
    assign q     = r_q;

    // Clear has priority; otherwise remember any enabled set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= q_now;
        end
    end

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game-flow controller: per-frame death/score decision, turn
// alternation, 4-bit scores and respawn requests.
// Optional feature macro: FROG_GRACE_EN (post-respawn collision grace counter).
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int WIN_SCORE    = 10,
    parameter int GRACE_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    frog_game_ctrl_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t             r_state;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic               r_respawn;
    logic [1:0]         r_winner;

    logic               w_in_game;
    logic               w_grace_active;
    logic               w_hit_q;
    logic               w_hit_now;
    logic [SCORE_W-1:0] w_score_inc;

    assign w_in_game   = (r_state == QGAME_1) || (r_state == QGAME_2);
    assign w_score_inc = ((r_state == QGAME_1) ? r_p1_score : r_p2_score) + SCORE_W'(1);

`ifdef FROG_GRACE_EN
    logic [7:0] r_grace;

    // Reload on each respawn pulse, then count frames down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grace <= 8'd0;
        end else if (r_respawn) begin
            r_grace <= 8'(GRACE_FRAMES);
        end else if (bus.frame_end && (r_grace != 8'd0)) begin
            r_grace <= r_grace - 8'd1;
        end
    end

    assign w_grace_active = (r_grace != 8'd0);
`else
    // No grace window: always false, GRACE_FRAMES is legal-range positive.
    assign w_grace_active = (GRACE_FRAMES < 0);
`endif

    // Collisions during the respawn pulse belong to the old position.
    frog_hit_latch u_hit_latch (
        .clk   (clk),
        .reset (reset),
        .en    (w_in_game & ~r_respawn & ~w_grace_active),
        .set   (bus.collision),
        .clr   (bus.frame_end | ~w_in_game),
        .q     (w_hit_q),
        .q_now (w_hit_now)
    );

    // Game FSM with registered outputs; decisions are taken on frame_end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= QI;
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_respawn  <= 1'b0;
            r_winner   <= WIN_NONE;
        end else begin
            r_respawn <= 1'b0;
            case (r_state)
                QI: begin
                    r_p1_score <= '0;
                    r_p2_score <= '0;
                    r_winner   <= WIN_NONE;
                    if (bus.start) begin
                        r_state   <= QGAME_1;
                        r_respawn <= ~r_respawn;
                    end
                end
                QGAME_1, QGAME_2: begin
                    if (!bus.start) begin
                        r_state <= QI;
                    end else if (bus.frame_end) begin
                        if (w_hit_now) begin
                            r_state   <= other_turn(r_state);
                            r_respawn <= ~r_respawn;
                        end else if (bus.goal) begin
                            if (r_state == QGAME_1) r_p1_score <= w_score_inc;
                            else                    r_p2_score <= w_score_inc;
                            if (w_score_inc == WIN_VAL) begin
                                r_state  <= QDONE;
                                r_winner <= (r_state == QGAME_1) ? WIN_P1 : WIN_P2;
                            end else begin
                                r_state   <= other_turn(r_state);
                                r_respawn <= ~r_respawn;
                            end
                        end
                    end
                end
                QDONE: begin
                    if (!bus.start) begin
                        r_state  <= QI;
                        r_winner <= WIN_NONE;
                    end
                end
                default: r_state <= QI;
            endcase
        end
    end

    assign bus.state    = r_state;
    assign bus.p1_score = r_p1_score;
    assign bus.p2_score = r_p2_score;
    assign bus.respawn  = r_respawn;
    assign bus.winner   = r_winner;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: directed vector table, hand-written
// grace / async-reset sequences, then randomized play against a model.
module tb_frog_game_ctrl;
    import frog_pkg::*;

    localparam int WIN   = 2;
    localparam int GRACE = 2;
`ifdef FROG_GRACE_EN
    localparam bit GRACE_ON = 1'b1;
`else
    localparam bit GRACE_ON = 1'b0;
`endif

    typedef struct {
        logic       st, fe, co, go;
        logic [1:0] s;
        logic [3:0] p1, p2;
        logic       r;
        logic [1:0] w;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frog_game_ctrl_if bus ();

    frog_game_ctrl #(
        .WIN_SCORE    (WIN),
        .GRACE_FRAMES (GRACE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: phase 0 idle, 1 = P1's turn, 2 = P2's turn, 3 = over.
    int m_phase;
    int m_score[2];
    int m_win;
    bit m_resp;
    bit m_hit;
    int m_grace;

    function automatic void model_reset();
        m_phase = 0; m_score[0] = 0; m_score[1] = 0; m_win = 0;
        m_resp = 0; m_hit = 0; m_grace = 0;
    endfunction

    function automatic void model_step(bit st, bit fe, bit co, bit go);
        bit playing = (m_phase == 1) || (m_phase == 2);
        bit hit_now = m_hit || (co && playing && !m_resp && m_grace == 0);
        bit want = 0;
        int p;
        // grace counter uses the pre-edge respawn value
        if (GRACE_ON) begin
            if (m_resp) m_grace = GRACE;
            else if (fe && m_grace > 0) m_grace = m_grace - 1;
        end
        m_hit = (fe || !playing) ? 1'b0 : hit_now;
        if (m_phase == 0) begin
            m_score[0] = 0; m_score[1] = 0; m_win = 0;
            if (st) begin m_phase = 1; want = 1; end
        end else if (playing) begin
            p = m_phase - 1;
            if (!st) m_phase = 0;
            else if (fe) begin
                if (hit_now) begin
                    m_phase = 3 - m_phase; want = 1;
                end else if (go) begin
                    m_score[p] = m_score[p] + 1;
                    if (m_score[p] == WIN) begin
                        m_phase = 3; m_win = p + 1;
                    end else begin
                        m_phase = 3 - m_phase; want = 1;
                    end
                end
            end
        end else begin
            if (!st) begin m_phase = 0; m_win = 0; end
        end
        m_resp = want && !m_resp;
    endfunction

    function automatic logic [12:0] pack(int s, int p1, int p2, bit r, int w);
        return {2'(s), 4'(p1), 4'(p2), r, 2'(w)};
    endfunction

    function automatic logic [12:0] model_vec();
        return pack(m_phase, m_score[0], m_score[1], m_resp, m_win);
    endfunction

    task automatic check(input string name, input logic [12:0] exp, input bit verbose);
        logic [12:0] act;
        act = {bus.state, bus.p1_score, bus.p2_score, bus.respawn, bus.winner};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d p1=%0d p2=%0d resp=%0b win=%0d, expected state=%0d p1=%0d p2=%0d resp=%0b win=%0d",
                     name, act[12:11], act[10:7], act[6:3], act[2], act[1:0],
                     exp[12:11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
        end else if (verbose) begin
            $display("ok   %s: state=%0d p1=%0d p2=%0d resp=%0b win=%0d",
                     name, act[12:11], act[10:7], act[6:3], act[2], act[1:0]);
        end
    endtask

    // Drive inputs away from the edge, advance the model, sample #1 after the edge.
    task automatic step(input bit st, input bit fe, input bit co, input bit go);
        @(negedge clk);
        bus.start = st; bus.frame_end = fe; bus.collision = co; bus.goal = go;
        model_step(st, fe, co, go);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.start = 0; bus.frame_end = 0; bus.collision = 0; bus.goal = 0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(bit st, bit fe, bit co, bit go, int s, int p1, int p2, bit r, int w);
        vec_t v;
        v.st = st; v.fe = fe; v.co = co; v.go = go;
        v.s = 2'(s); v.p1 = 4'(p1); v.p2 = 4'(p2); v.r = r; v.w = 2'(w);
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.frame_end = 0; bus.collision = 0; bus.goal = 0;
        model_reset();

        // start, P1 scores, two empty frames, P2 hit+goal, P1 wins, release
        tbl[0]  = mk(0,0,0,0, 0,0,0,0,0);
        tbl[1]  = mk(1,0,0,0, 1,0,0,1,0);
        tbl[2]  = mk(1,0,0,0, 1,0,0,0,0);
        tbl[3]  = mk(1,0,0,1, 1,0,0,0,0);
        tbl[4]  = mk(1,1,0,1, 2,1,0,1,0);
        tbl[5]  = mk(1,0,0,0, 2,1,0,0,0);
        tbl[6]  = mk(1,1,0,0, 2,1,0,0,0);
        tbl[7]  = mk(1,1,0,0, 2,1,0,0,0);
        tbl[8]  = mk(1,0,1,0, 2,1,0,0,0);
        tbl[9]  = mk(1,0,1,0, 2,1,0,0,0);
        tbl[10] = mk(1,0,1,0, 2,1,0,0,0);
        tbl[11] = mk(1,1,0,1, 1,1,0,1,0);
        tbl[12] = mk(1,0,0,0, 1,1,0,0,0);
        tbl[13] = mk(1,1,0,1, 3,2,0,0,1);
        tbl[14] = mk(1,1,0,1, 3,2,0,0,1);
        tbl[15] = mk(0,0,0,0, 0,2,0,0,0);
        tbl[16] = mk(0,0,0,0, 0,0,0,0,0);

        #1;
        check("reset_state", pack(0,0,0,0,0), 1'b1);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].st, tbl[i].fe, tbl[i].co, tbl[i].go);
            check($sformatf("table[%0d]", i),
                  {tbl[i].s, tbl[i].p1, tbl[i].p2, tbl[i].r, tbl[i].w}, 1'b1);
        end

        // Grace window: collisions on the frame_end cycle of early frames.
        do_reset();
        step(1,0,0,0); check("grace_start", pack(1,0,0,1,0), 1'b1);
        step(1,0,0,0); check("grace_idle", pack(1,0,0,0,0), 1'b1);
        step(1,1,1,0);
        if (GRACE_ON) check("grace_frame1", pack(1,0,0,0,0), 1'b1);
        else          check("nograce_frame1", pack(2,0,0,1,0), 1'b1);
        if (GRACE_ON) begin
            step(1,1,1,0); check("grace_frame2", pack(1,0,0,0,0), 1'b1);
            step(1,1,1,0); check("grace_frame3", pack(2,0,0,1,0), 1'b1);
        end

        // Asynchronous reset with the hit latched, then a clean frame.
        do_reset();
        step(1,0,0,0); check("rst_start", pack(1,0,0,1,0), 1'b1);
        step(1,0,0,0);
        step(1,0,0,1); step(1,1,0,1); check("rst_score", pack(2,1,0,1,0), 1'b1);
        step(1,0,0,0);
        step(1,1,0,0); step(1,1,0,0);
        step(1,0,1,0); check("rst_hit_latched", pack(2,1,0,0,0), 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check("async_reset", pack(0,0,0,0,0), 1'b1);
        @(negedge clk);
        bus.start = 0; bus.collision = 0; bus.goal = 0; bus.frame_end = 0;
        reset = 1'b0;
        step(1,0,0,0); check("restart", pack(1,0,0,1,0), 1'b1);
        step(1,0,0,0);
        step(1,1,0,0); check("clean_frame", pack(1,0,0,0,0), 1'b1);

        // Abort mid-game.
        step(0,1,0,1); check("abort", pack(0,0,0,0,0), 1'b1);

        // Randomized play against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit st, fe, co, go;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            st = ($urandom_range(0, 39) != 0);
            fe = ($urandom_range(0, 5) == 0);
            co = ($urandom_range(0, 9) == 0);
            go = ($urandom_range(0, 2) == 0);
            step(st, fe, co, go);
            check($sformatf("rand[%0d]", i), model_vec(), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
